// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern framer transmitter and its matching detector.
package pattern_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, DATA} tx_state_t;

  localparam int unsigned PATTERN_W = 4;
  localparam logic [PATTERN_W-1:0] DEF_PATTERN = 4'b1010;

  // Bit counter must hold both the sync index (3) and DATA_W-1.
  function automatic int unsigned idx_width(input int unsigned data_w);
    return (data_w > PATTERN_W) ? $clog2(data_w) : $clog2(PATTERN_W);
  endfunction

endpackage

// File: rtl/pattern_framer_tx_if.sv
// Payload valid/ready handshake into the framer.
interface pattern_framer_tx_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/pattern_framer_tx_piso.sv
// Parallel-load, MSB-first shift register feeding the serial line.
module pattern_piso #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         q_msb
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n)     r_q <= '0;
    else if (load)  r_q <= d;
    else if (shift) r_q <= r_q << 1;
  end

  assign q_msb = r_q[W-1];

endmodule

// File: rtl/pattern_framer_tx.sv
// Frames each accepted payload word as PATTERN followed by the word, MSB first,
// on a registered serial line; one-entry holding register decouples the handshake.
module pattern_framer_tx
  import pattern_pkg::*;
#(
  parameter logic [PATTERN_W-1:0] PATTERN  = DEF_PATTERN,
  parameter int unsigned          DATA_W   = 8,
  parameter logic                 IDLE_BIT = 1'b0,
  parameter int unsigned          CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pattern_framer_tx_if.slave      i_in,
  output logic                    bit_stream,
  output logic                    bit_valid,
  output logic                    frame_start,
  output logic                    busy,
  output logic [CNT_W-1:0]        frame_cnt
);

  localparam int unsigned IDX_W = idx_width(DATA_W);

  tx_state_t          r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_bit_idx, w_idx_nxt;
  logic [DATA_W-1:0]  r_hold_data;
  logic               r_hold_full, w_hold_full_nxt;
  logic [CNT_W-1:0]   r_frame_cnt;
  logic               r_bit_stream, r_bit_valid, r_frame_start, r_busy;
  logic               w_accept, w_load, w_shift, w_cnt_inc, w_bit_nxt, w_q_msb;

  assign w_accept        = i_in.in_valid & ~r_hold_full;
  assign w_hold_full_nxt = w_accept ? 1'b1 : (w_load ? 1'b0 : r_hold_full);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_idx <= w_idx_nxt;
    end
  end

  // Next state; line outputs are computed for the next state so they register cleanly.
  // The shift register runs one bit ahead, so q_msb is already the next payload bit.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_bit_idx;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_cnt_inc   = 1'b0;
    w_bit_nxt   = IDLE_BIT;
    case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_state_nxt = SYNC;
          w_load      = 1'b1;
          w_idx_nxt   = IDX_W'(PATTERN_W - 1);
        end
      end
      SYNC: begin
        if (r_bit_idx == '0) begin
          w_state_nxt = DATA;
          w_idx_nxt   = IDX_W'(DATA_W - 1);
          w_shift     = 1'b1;
        end else begin
          w_idx_nxt   = r_bit_idx - 1'b1;
        end
      end
      DATA: begin
        if (r_bit_idx == '0) begin
          w_cnt_inc = 1'b1;
          if (r_hold_full) begin
            w_state_nxt = SYNC;
            w_load      = 1'b1;
            w_idx_nxt   = IDX_W'(PATTERN_W - 1);
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_idx_nxt = r_bit_idx - 1'b1;
          w_shift   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    case (w_state_nxt)
      SYNC:    w_bit_nxt = PATTERN[w_idx_nxt[1:0]];
      DATA:    w_bit_nxt = w_q_msb;
      default: w_bit_nxt = IDLE_BIT;
    endcase
  end

  // Holding register, frame counter and registered line outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_data   <= '0;
      r_hold_full   <= 1'b0;
      r_frame_cnt   <= '0;
      r_bit_stream  <= IDLE_BIT;
      r_bit_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      if (w_accept) r_hold_data <= i_in.in_data;
      r_hold_full   <= w_hold_full_nxt;
      if (w_cnt_inc) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      r_bit_stream  <= w_bit_nxt;
      r_bit_valid   <= (w_state_nxt != IDLE);
      r_frame_start <= w_load;
      r_busy        <= (w_state_nxt != IDLE) | w_hold_full_nxt;
    end
  end

  pattern_piso #(.W(DATA_W)) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .shift (w_shift),
    .d     (r_hold_data),
    .q_msb (w_q_msb)
  );

  assign i_in.in_ready = ~r_hold_full;
  assign bit_stream    = r_bit_stream;
  assign bit_valid     = r_bit_valid;
  assign frame_start   = r_frame_start;
  assign busy          = r_busy;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: doc/pattern_framer_tx.md
# pattern_framer_tx

Serial framing transmitter that feeds the pattern detector. Parallel payload words arrive over a valid/ready handshake. Each word goes out on a single-bit stream, MSB first, preceded by the 4-bit PATTERN sync marker. Between frames the line idles at IDLE_BIT. The block sits on the transmit side of the link, opposite the detector, and also serves as its loopback stimulus source in bench and bring-up.

## Interface
- PATTERN, 4'b1010, sync marker; sent MSB first at the start of every frame.
- DATA_W, 8, payload width in bits; legal range 1..32.
- IDLE_BIT, 1'b0, line level driven when no frame is active.
- CNT_W, 16, width of frame_cnt.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_data  in  DATA_W  payload word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  holding register empty; word accepted on in_valid & in_ready.
- bit_stream  out  1  serial line, registered.
- bit_valid  out  1  high while bit_stream carries a sync or payload bit.
- frame_start  out  1  one-cycle pulse, coincident with the first sync bit.
- busy  out  1  state != IDLE or holding register full.
- frame_cnt  out  CNT_W  completed-frame count; wraps.

## Operation
- One-entry holding register (hold_data, hold_full) decouples the handshake from serialization.
  - in_ready = ~hold_full, combinational from the flop.
  - Accepting sets hold_full.
- FSM states: IDLE, SYNC, DATA. Bit counter bit_idx is $clog2(max(4, DATA_W)) wide.
- IDLE
  - bit_stream = IDLE_BIT, bit_valid = 0.
  - If hold_full: go to SYNC, shift_reg <= hold_data, clear hold_full, bit_idx <= 3.
- SYNC
  - bit_stream = PATTERN[bit_idx], bit_valid = 1; frame_start = 1 on bit_idx 3 only.
  - At bit_idx 0: go to DATA, bit_idx <= DATA_W-1.
- DATA
  - bit_stream = shift_reg[MSB], shift left each cycle, bit_valid = 1.
  - At the last bit: frame_cnt += 1, mod 2^CNT_W.
  - After the last bit: if hold_full, reload and go straight to SYNC (back-to-back, zero idle gap); else go to IDLE.
- A word may be accepted while a frame is in flight, because the holding register is freed at load.
- Accept and load never occur on the same edge, since accept requires hold_full = 0.
- in_data is sampled only at the accepting edge. in_valid without in_ready is ignored; a held word stays stable.
- Frame length is fixed at 4 + DATA_W bit times.

## Timing
- Reset values: in_ready = 1, bit_stream = IDLE_BIT, bit_valid = 0, frame_start = 0, busy = 0, frame_cnt = 0, state = IDLE, hold_full = 0.
- Latency from an idle line:
  - Handshake in cycle k.
  - hold_full is high in cycle k+1.
  - First sync bit appears on bit_stream in cycle k+2.
- Back-to-back: the next frame's PATTERN[3] follows the previous payload LSB in the very next cycle.
- Sustained throughput: one word per 4 + DATA_W cycles.
- Reset mid-frame: the frame is aborted and the held word discarded. The cycle after the reset edge shows reset values, and no partial-frame count is recorded.
- frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.

## Structure
- Shared package pattern_pkg holds:
  - typedef enum logic [1:0] {IDLE, SYNC, DATA} tx_state_t;
  - localparam PATTERN_W = 4;
  - the default PATTERN constant, shared with the detector.
- Sub-module pattern_piso: parallel-load, MSB-first shift register with ports load, shift, d, q_msb.
- The FSM, holding register and counter live in the top module.

## Test plan
- Single frame: in_data = 8'hC3 from idle → bit_stream 1,0,1,0,1,1,0,0,0,0,1,1 over cycles k+2..k+13, frame_start only at k+2, then IDLE_BIT, frame_cnt = 1.
- Back-to-back: 8'hFF then 8'h00 presented continuously → 24 contiguous valid bits, in_ready low only while the holding register is full, frame_cnt = 2.
- Backpressure: in_valid held with 8'h5A while both shift register and holding register are busy → in_ready = 0, word stays stable until accepted, no drop or duplicate.
- Reset mid-frame: rst_n low at the 6th frame bit → next cycle shows reset values, frame_cnt = 0; a subsequent 8'hA5 is framed correctly.
- Wrap: CNT_W = 2, five frames → frame_cnt sequence 1, 2, 3, 0, 1.
- Loopback into the detector with PATTERN = 4'b1010 → found asserted at each sync marker position.
